// File: rtl/instr_mem_ctrl.sv
`timescale 1ns/1ps
// instr_mem_ctrl: instruction memory behind a req/gnt/rvalid fetch handshake with LATENCY-deep
// response pipeline. Optional word write port when INSTR_MEM_WRPORT_EN is defined.
module instr_mem_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       LATENCY   = 1,
    parameter int unsigned       MAX_OUTST = 2,
    parameter                    INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o
`ifdef INSTR_MEM_WRPORT_EN
    ,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
`endif
);

    localparam int unsigned       BYTE_N     = DATA_W / 8;
    localparam int unsigned       OFF_W      = $clog2(BYTE_N);
    localparam int unsigned       IDX_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W:0]   END_ADDR   = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * BYTE_N);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTE_N - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-side address decode
    logic [ADDR_W-1:0] rd_off;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_err;
    logic              unused_rd_off;

    assign rd_off        = instr_addr_i - BASE_ADDR;
    assign rd_idx        = rd_off[OFF_W +: IDX_W];
    assign unused_rd_off = ^rd_off;
    assign rd_err        = ((instr_addr_i & ALIGN_MASK) != '0)
                        || (instr_addr_i < BASE_ADDR)
                        || ({1'b0, instr_addr_i} >= END_ADDR);

    logic [CNT_W-1:0] outst_cnt_reg;
    logic [CNT_W-1:0] outst_cnt_next;
    logic             accept;
    logic             resp_issue;

    assign instr_gnt_o = instr_req_i & rst_ni & (outst_cnt_reg < CNT_W'(MAX_OUTST));
    assign accept      = instr_req_i & instr_gnt_o;

    logic              valid_pipe_reg [LATENCY];
    logic              err_pipe_reg   [LATENCY];
    logic [DATA_W-1:0] data_pipe_reg  [LATENCY];

    // The outstanding slot is released on the edge that launches rvalid, so a new request can be
    // granted in the same cycle its predecessor's response is presented.
    if (LATENCY == 1) begin : g_issue_direct
        assign resp_issue = accept;
    end else begin : g_issue_pipe
        assign resp_issue = valid_pipe_reg[LATENCY-2];
    end

    always_comb begin
        outst_cnt_next = outst_cnt_reg;
        if (accept && !resp_issue) begin
            outst_cnt_next = outst_cnt_reg + CNT_W'(1);
        end else if (!accept && resp_issue) begin
            outst_cnt_next = outst_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outst_cnt_reg <= '0;
        end else begin
            outst_cnt_reg <= outst_cnt_next;
        end
    end

    // Stage 0: memory is read on the accept edge; errored accesses carry zero data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_pipe_reg[0] <= 1'b0;
            err_pipe_reg[0]   <= 1'b0;
            data_pipe_reg[0]  <= '0;
        end else begin
            valid_pipe_reg[0] <= accept;
            if (accept) begin
                err_pipe_reg[0]  <= rd_err;
                data_pipe_reg[0] <= rd_err ? '0 : mem[rd_idx];
            end
        end
    end

    // Later stages only move data with a valid token so the outputs hold between responses.
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_pipe_reg[gi] <= 1'b0;
                err_pipe_reg[gi]   <= 1'b0;
                data_pipe_reg[gi]  <= '0;
            end else begin
                valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
                if (valid_pipe_reg[gi-1]) begin
                    err_pipe_reg[gi]  <= err_pipe_reg[gi-1];
                    data_pipe_reg[gi] <= data_pipe_reg[gi-1];
                end
            end
        end
    end

    assign instr_rvalid_o = valid_pipe_reg[LATENCY-1];
    assign instr_err_o    = err_pipe_reg[LATENCY-1];
    assign instr_rdata_o  = data_pipe_reg[LATENCY-1];

`ifdef INSTR_MEM_WRPORT_EN
    logic [ADDR_W-1:0] wr_off;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_err;
    logic              unused_wr_off;

    assign wr_off        = wr_addr_i - BASE_ADDR;
    assign wr_idx        = wr_off[OFF_W +: IDX_W];
    assign unused_wr_off = ^wr_off;
    assign wr_err        = ((wr_addr_i & ALIGN_MASK) != '0)
                        || (wr_addr_i < BASE_ADDR)
                        || ({1'b0, wr_addr_i} >= END_ADDR);

    // A same-edge read of this word sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en_i && !wr_err) begin
            mem[wr_idx] <= wr_data_i;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
`timescale 1ns/1ps
// tb_instr_mem_ctrl: scoreboard bench over four latency/outstanding configurations of
// instr_mem_ctrl; the write-port test runs when INSTR_MEM_WRPORT_EN is defined.
module tb_instr_mem_ctrl;

    localparam int N_DUT = 4;
    localparam int LAT_TAB [N_DUT] = '{1, 3, 3, 2};
    localparam int MO_TAB  [N_DUT] = '{1, 3, 1, 2};

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n  [N_DUT];
    logic        req    [N_DUT];
    logic [31:0] addr   [N_DUT];
    logic        gnt    [N_DUT];
    logic        rvalid [N_DUT];
    logic [31:0] rdata  [N_DUT];
    logic        err    [N_DUT];
`ifdef INSTR_MEM_WRPORT_EN
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt  [N_DUT] = '{default: 0};
    int   resp_cnt [N_DUT] = '{default: 0};
    int   max_seen [N_DUT] = '{default: 0};
    exp_t exp_q    [N_DUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] img(input int w);
        if (w == 0) return 32'h00100093;
        return 32'hC0DE0000 | 32'(w);
    endfunction

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        instr_mem_ctrl #(
            .ADDR_W   (32),
            .DATA_W   (32),
            .DEPTH    (1024),
            .BASE_ADDR(32'h0),
            .LATENCY  (LAT_TAB[gi]),
            .MAX_OUTST(MO_TAB[gi]),
            .INIT_FILE("")
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n[gi]),
            .instr_req_i   (req[gi]),
            .instr_addr_i  (addr[gi]),
            .instr_gnt_o   (gnt[gi]),
            .instr_rvalid_o(rvalid[gi]),
            .instr_rdata_o (rdata[gi]),
            .instr_err_o   (err[gi])
`ifdef INSTR_MEM_WRPORT_EN
            ,
            .wr_en_i       (wr_en),
            .wr_addr_i     (wr_addr),
            .wr_data_i     (wr_data)
`endif
        );
`ifndef INSTR_MEM_WRPORT_EN
        initial begin
            for (int w = 0; w < 16; w++) u_dut.mem[w] = img(w);
            u_dut.mem[1023] = img(1023);
        end
`endif
    end

    // Monitor: pops the scoreboard whenever a DUT presents rvalid.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < N_DUT; k++) begin
            if (rvalid[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 data=%h at cyc %0d, expected no response",
                             k, rdata[k], cyc);
                end else begin
                    e = exp_q[k].pop_front();
                    resp_cnt[k]++;
                    $display("dut%0d rsp cyc=%0d data=%h err=%b", k, cyc, rdata[k], err[k]);
                    checks++;
                    if (rdata[k] !== e.data || err[k] !== e.err) begin
                        errors++;
                        $display("FAIL resp_data dut%0d: got data=%h err=%b, expected data=%h err=%b",
                                 k, rdata[k], err[k], e.data, e.err);
                    end
                    checks++;
                    if (32'(cyc) !== e.due) begin
                        errors++;
                        $display("FAIL resp_latency dut%0d: got rvalid at cyc %0d, expected cyc %0d",
                                 k, cyc, e.due);
                    end
                end
            end
            if (acc_cnt[k] - resp_cnt[k] > max_seen[k]) max_seen[k] = acc_cnt[k] - resp_cnt[k];
        end
    end

    // Holds req until granted, then pushes the expected response with its due cycle.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d, input logic e,
                         output int acc_cyc, output int waited);
        exp_t x;
        acc_cyc = -1;
        waited  = 0;
        @(negedge clk);
        req[k]  = 1'b1;
        addr[k] = a;
        #1;
        while (gnt[k] !== 1'b1 && waited < 30) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (gnt[k] === 1'b1) begin
            acc_cyc = cyc + 1;
            x.data  = d;
            x.err   = e;
            x.due   = 32'(cyc + LAT_TAB[k]);
            exp_q[k].push_back(x);
            acc_cnt[k]++;
        end else begin
            checks++; errors++;
            $display("FAIL grant_timeout dut%0d addr=%h: no gnt after %0d cycles, expected gnt", k, a, waited);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (exp_q[k].size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q[k].size() != 0) begin
            errors++;
            $display("FAIL drain_timeout dut%0d: got %0d responses missing, expected 0", k, exp_q[k].size());
        end
    endtask

    logic [31:0] seq_addr [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [31:0] seq_data [6] = '{32'h00100093, 32'hC0DE0001, 32'hC0DE0002,
                                  32'hC0DE0003, 32'hC0DE0004, 32'hC0DE0005};
    logic [31:0] err_addr [5] = '{32'h2, 32'h1000, 32'hFFC, 32'hFFFFFFFC, 32'h4};
    logic [31:0] err_data [5] = '{32'h0, 32'h0, 32'hC0DE03FF, 32'h0, 32'hC0DE0001};
    logic        err_flag [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int ac, w, prev;
        for (int k = 0; k < N_DUT; k++) begin
            rst_n[k] = 1'b0;
            req[k]   = 1'b1;
            addr[k]  = 32'h0;
        end
`ifdef INSTR_MEM_WRPORT_EN
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
`endif
        // Reset held with req asserted: everything must stay quiet.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state dut%0d cyc %0d: got gnt=%b rvalid=%b rdata=%h err=%b, expected all 0",
                             k, c, gnt[k], rvalid[k], rdata[k], err[k]);
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            req[k]   = 1'b0;
            rst_n[k] = 1'b1;
        end
`ifdef INSTR_MEM_WRPORT_EN
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = (i == 16) ? 32'hFFC : 32'(i * 4);
            wr_data = img((i == 16) ? 1023 : i);
        end
        @(negedge clk);
        wr_en = 1'b0;
`endif

        // LATENCY=1: granted immediately, data the next cycle.
        issue(0, 32'h0, 32'h00100093, 1'b0, ac, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL lat1_gnt dut0: got gnt after %0d waits, expected 0", w);
        end
        idle(0);
        drain(0);

        // LATENCY=3, MAX_OUTST=3: six back-to-back accepts.
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            issue(1, seq_addr[i], seq_data[i], 1'b0, ac, w);
            if (i > 0) begin
                checks++;
                if (ac - prev != 1) begin
                    errors++;
                    $display("FAIL b2b_spacing dut1 req%0d: got accept gap %0d, expected 1", i, ac - prev);
                end
            end
            prev = ac;
        end
        idle(1);
        drain(1);
        checks++;
        if (max_seen[1] > 3 || max_seen[1] < 2) begin
            errors++;
            $display("FAIL outst_max dut1: got %0d, expected 2..3", max_seen[1]);
        end

        // LATENCY=3, MAX_OUTST=1: grants every third cycle.
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(2, seq_addr[i], seq_data[i], 1'b0, ac, w);
            if (i > 0) begin
                checks++;
                if (ac - prev != 3) begin
                    errors++;
                    $display("FAIL mo1_spacing dut2 req%0d: got accept gap %0d, expected 3", i, ac - prev);
                end
            end
            prev = ac;
        end
        idle(2);
        drain(2);
        checks++;
        if (max_seen[2] != 1) begin
            errors++;
            $display("FAIL outst_max dut2: got %0d, expected 1", max_seen[2]);
        end

        // Misaligned, out-of-range and last-word accesses.
        for (int i = 0; i < 5; i++) issue(0, err_addr[i], err_data[i], err_flag[i], ac, w);
        idle(0);
        drain(0);

        // LATENCY=2: reset one cycle after accept drops the response.
        issue(3, 32'h4, 32'hC0DE0001, 1'b0, ac, w);
        @(negedge clk);
        req[3]   = 1'b0;
        rst_n[3] = 1'b0;
        exp_q[3].delete();
        acc_cnt[3] = resp_cnt[3];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rvalid[3] !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop dut3: got rvalid=%b after reset, expected 0", rvalid[3]);
            end
        end
        @(negedge clk);
        rst_n[3] = 1'b1;
        issue(3, 32'h8, 32'hC0DE0002, 1'b0, ac, w);
        idle(3);
        drain(3);

`ifdef INSTR_MEM_WRPORT_EN
        // Write and read the same word in one cycle: the read returns the old word.
        begin
            exp_t x;
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 32'h8;
            wr_data = 32'hDEADBEEF;
            req[0]  = 1'b1;
            addr[0] = 32'h8;
            #1;
            checks++;
            if (gnt[0] !== 1'b1) begin
                errors++;
                $display("FAIL wr_rd_gnt dut0: got gnt=%b, expected 1", gnt[0]);
            end else begin
                x.data = 32'hC0DE0002;
                x.err  = 1'b0;
                x.due  = 32'(cyc + 1);
                exp_q[0].push_back(x);
                acc_cnt[0]++;
            end
            @(negedge clk);
            wr_en  = 1'b0;
            req[0] = 1'b0;
        end
        issue(0, 32'h8, 32'hDEADBEEF, 1'b0, ac, w);
        idle(0);
        drain(0);
`endif

        repeat (4) @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL sb_empty dut%0d: got %0d pending, expected 0", k, exp_q[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
